// File: rtl/mmr_noc_tx_if.sv
// rtl/mmr_noc_tx_if.sv - MMR write-snoop and NoC transmit link bundle for mmr_noc_tx
//
// Purpose: groups the write-back MMR snoop port and the outbound NoC
// valid/ready link so the transmitter and its environment share one bundle.
//
// Signals:
//   mmr_we        write-back MMR write strobe
//   mmr_location  MMR byte address of the write
//   mmr_wdata     MMR write data
//   mmr_stall     write refused this cycle; writer must hold and retry
//   noc_tx_valid  flit on noc_tx_data is valid
//   noc_tx_ready  NoC accepts the flit this cycle
//   noc_tx_data   flit payload
//   noc_tx_last   final flit of a packet
//   noc_tx_done   one-cycle pulse after the final flit is accepted
//   busy          a packet is in flight
//
// Modports:
//   master  write-back / NoC side (drives writes and ready)
//   slave   the transmitter
`timescale 1ns/1ps

interface mmr_noc_tx_if;
    logic        mmr_we;
    logic [31:0] mmr_location;
    logic [31:0] mmr_wdata;
    logic        mmr_stall;
    logic        noc_tx_valid;
    logic        noc_tx_ready;
    logic [31:0] noc_tx_data;
    logic        noc_tx_last;
    logic        noc_tx_done;
    logic        busy;

    modport master (
        output mmr_we,
        output mmr_location,
        output mmr_wdata,
        output noc_tx_ready,
        input  mmr_stall,
        input  noc_tx_valid,
        input  noc_tx_data,
        input  noc_tx_last,
        input  noc_tx_done,
        input  busy
    );

    modport slave (
        input  mmr_we,
        input  mmr_location,
        input  mmr_wdata,
        input  noc_tx_ready,
        output mmr_stall,
        output noc_tx_valid,
        output noc_tx_data,
        output noc_tx_last,
        output noc_tx_done,
        output busy
    );
endinterface

// File: rtl/mmr_noc_tx.sv
// rtl/mmr_noc_tx.sv - store-side NoC transmitter snooping MMR write-back writes
//
// Purpose: shadows NUM_WORDS payload words and a command word written through
// the MMR window at BASE_ADDR. A command write with bit0=1 launches a packet:
// one header flit (the command word) followed by NUM_WORDS payload flits over
// a valid/ready link, then a one-cycle done pulse.
//
// Ports:
//   clk    in  single clock, posedge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of mmr_noc_tx_if (MMR snoop + NoC link, see interface)
`timescale 1ns/1ps

module mmr_noc_tx #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_4000,
    parameter int unsigned NUM_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    mmr_noc_tx_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Word index of the command register; payload indices are below it.
    localparam logic [2:0] CMD_IDX  = 3'(NUM_WORDS);
    localparam logic [2:0] LAST_IDX = 3'(NUM_WORDS - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_count;
    logic [31:0] r_cmd;
    // Sized to the full 3-bit index space; entries at or above NUM_WORDS are
    // never written and stay at zero.
    logic [31:0] r_shadow [0:7];

    logic [2:0]  w_idx;
    logic        w_hit;
    logic        w_busy;
    logic        w_accept_wr;
    logic        w_trigger;
    logic        w_last;
    logic        w_valid;
    logic [31:0] w_data;
    logic        w_done;

    assign w_idx = bus.mmr_location[4:2];

    assign w_hit = bus.mmr_we
                && (bus.mmr_location[31:5] == BASE_ADDR[31:5])
                && (bus.mmr_location[1:0] == 2'b00)
                && (w_idx <= CMD_IDX);

    assign w_busy = (r_state != S_IDLE);

    // Writes are only taken in IDLE, which also freezes the shadow words for
    // the whole life of a packet.
    assign w_accept_wr = w_hit && !w_busy;
    assign w_trigger   = w_accept_wr && (w_idx == CMD_IDX) && bus.mmr_wdata[0];
    assign w_last      = (r_state == S_DATA) && (r_count == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: if (w_trigger)                    w_next_state = S_HDR;
            S_HDR:  if (bus.noc_tx_ready)             w_next_state = S_DATA;
            S_DATA: if (bus.noc_tx_ready && w_last)   w_next_state = S_DONE;
            S_DONE:                                   w_next_state = S_IDLE;
            default:                                  w_next_state = S_IDLE;
        endcase
    end

    // Payload index: cleared when the header is accepted, advanced on each
    // accepted payload flit except the last, so it never passes LAST_IDX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 3'd0;
        end else if (r_state == S_HDR && bus.noc_tx_ready) begin
            r_count <= 3'd0;
        end else if (r_state == S_DATA && bus.noc_tx_ready && !w_last) begin
            r_count <= r_count + 3'd1;
        end
    end

    // Shadow payload words and command word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd <= 32'd0;
            for (int i = 0; i < 8; i++) begin
                r_shadow[i] <= 32'd0;
            end
        end else if (w_accept_wr) begin
            if (w_idx == CMD_IDX) begin
                r_cmd <= bus.mmr_wdata;
            end else begin
                r_shadow[w_idx] <= bus.mmr_wdata;
            end
        end
    end

    // Outputs are decoded from state only, so valid/data/last stay stable
    // while a flit waits for ready.
    always_comb begin
        w_valid = 1'b0;
        w_data  = 32'd0;
        w_done  = 1'b0;
        unique case (r_state)
            S_HDR: begin
                w_valid = 1'b1;
                w_data  = r_cmd;
            end
            S_DATA: begin
                w_valid = 1'b1;
                w_data  = r_shadow[r_count];
            end
            S_DONE: begin
                w_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.noc_tx_valid = w_valid;
    assign bus.noc_tx_data  = w_data;
    assign bus.noc_tx_last  = w_last;
    assign bus.noc_tx_done  = w_done;
    assign bus.busy         = w_busy;
    assign bus.mmr_stall    = w_hit && w_busy;

endmodule

// File: tb/tb_mmr_noc_tx.sv
// tb/tb_mmr_noc_tx.sv - self-checking bench for mmr_noc_tx
`timescale 1ns/1ps

module tb_mmr_noc_tx;

    localparam logic [31:0] BASE = 32'h0000_4000;
    localparam int          NW   = 4;

    logic clk;
    logic rst_n;

    mmr_noc_tx_if bus ();

    mmr_noc_tx #(
        .BASE_ADDR (BASE),
        .NUM_WORDS (NW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: contents of the MMR window as seen by the transmitter.
    logic [31:0] m_shadow [0:NW-1];
    logic [31:0] m_cmd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NW; i++) m_shadow[i] = 32'd0;
        m_cmd = 32'd0;
    endtask

    // Applies an accepted write to the model; returns 1 if it launches a packet.
    function automatic bit model_write(input logic [31:0] addr, input logic [31:0] data);
        int idx;
        if (addr >= BASE && addr <= BASE + 4 * NW && (addr % 4) == 0) begin
            idx = int'((addr - BASE) / 4);
            if (idx < NW) begin
                m_shadow[idx] = data;
                return 1'b0;
            end
            m_cmd = data;
            return data[0];
        end
        return 1'b0;
    endfunction

    // Called at posedge+1 while the DUT is idle; returns at posedge+1 after the write.
    task automatic mmr_write(input logic [31:0] addr, input logic [31:0] data, input string tag);
        bit trig;
        bus.mmr_we       = 1'b1;
        bus.mmr_location = addr;
        bus.mmr_wdata    = data;
        #4;
        check({tag, "_stall"}, {31'd0, bus.mmr_stall}, 32'd0);
        @(posedge clk); #1;
        bus.mmr_we = 1'b0;
        trig = model_write(addr, data);
    endtask

    // Entered at posedge+1 of the first header cycle. mode 0: ready high,
    // 1: random ready, 2: ready low for 3 cycles while flit 2 is offered.
    task automatic run_packet(input int mode, input string tag, input bit busy_wr,
                              input bit b2b, input logic [31:0] b2b_cmd);
        logic [31:0] exp_q[$];
        logic [31:0] got_q[$];
        bit          pv;
        logic [31:0] pd;
        logic        pl;
        int          cyc;
        int          hold;
        int          acc_last;
        int          done_cyc;
        bit          done_seen;
        bit          trig;
        logic        r;

        exp_q.push_back(m_cmd);
        for (int i = 0; i < NW; i++) exp_q.push_back(m_shadow[i]);
        pv = 0; pd = 0; pl = 0; cyc = 0; hold = 0;
        acc_last = -10; done_cyc = -1; done_seen = 0;

        while (!done_seen && cyc < 300) begin
            if (mode == 0) r = 1'b1;
            else if (mode == 1) r = 1'($urandom_range(0, 1));
            else if (got_q.size() == 2 && hold < 3) begin r = 1'b0; hold++; end
            else r = 1'b1;
            bus.noc_tx_ready = r;
            if (busy_wr && cyc == 2) begin
                bus.mmr_we = 1'b1; bus.mmr_location = BASE + 32'h4; bus.mmr_wdata = 32'h99;
            end
            if (busy_wr && cyc == 3) bus.mmr_location = 32'h0000_5000;
            if (b2b && cyc == NW + 1) begin
                bus.mmr_we = 1'b1; bus.mmr_location = BASE + 4 * NW; bus.mmr_wdata = b2b_cmd;
            end
            #4;
            if (cyc == 0) check({tag, "_hdr_valid"}, {31'd0, bus.noc_tx_valid}, 32'd1);
            check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
            if (busy_wr && cyc == 2) check({tag, "_busy_write_stall"}, {31'd0, bus.mmr_stall}, 32'd1);
            if (busy_wr && cyc == 3) check({tag, "_busy_miss_stall"}, {31'd0, bus.mmr_stall}, 32'd0);
            if (b2b && cyc == NW + 1) check({tag, "_b2b_done_stall"}, {31'd0, bus.mmr_stall}, 32'd1);
            if (pv) begin
                check({tag, "_hold_valid"}, {31'd0, bus.noc_tx_valid}, 32'd1);
                check({tag, "_hold_data"}, bus.noc_tx_data, pd);
                check({tag, "_hold_last"}, {31'd0, bus.noc_tx_last}, {31'd0, pl});
            end
            if (bus.noc_tx_done === 1'b1) begin
                done_seen = 1;
                done_cyc  = cyc;
                check({tag, "_done_after_last"}, cyc, acc_last + 1);
                check({tag, "_done_valid"}, {31'd0, bus.noc_tx_valid}, 32'd0);
            end
            if (bus.noc_tx_valid === 1'b1 && r) begin
                got_q.push_back(bus.noc_tx_data);
                check({tag, "_last_flag"}, {31'd0, bus.noc_tx_last},
                      (got_q.size() == NW + 1) ? 32'd1 : 32'd0);
                acc_last = cyc;
                pv = 0;
            end else begin
                pv = bus.noc_tx_valid;
                pd = bus.noc_tx_data;
                pl = bus.noc_tx_last;
            end
            @(posedge clk); #1;
            if (busy_wr && cyc == 3) bus.mmr_we = 1'b0;
            cyc++;
        end

        check({tag, "_done_seen"}, {31'd0, done_seen}, 32'd1);
        if (mode == 0) check({tag, "_done_latency"}, done_cyc, NW + 1);
        check({tag, "_flit_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, "_flit", $sformatf("%0d", i)}, got_q[i], exp_q[i]);

        #4;
        check({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_idle_stall"}, {31'd0, bus.mmr_stall}, 32'd0);
        @(posedge clk); #1;
        if (b2b) begin
            bus.mmr_we = 1'b0;
            trig = model_write(BASE + 4 * NW, b2b_cmd);
        end
    endtask

    initial begin
        logic [31:0] miss_addr [0:4];
        logic [31:0] cmdv;
        bit          trig;
        miss_addr[0] = BASE + 32'h14;
        miss_addr[1] = BASE + 32'h2;
        miss_addr[2] = BASE - 32'h4;
        miss_addr[3] = BASE + 32'h20;
        miss_addr[4] = 32'h0000_5000;

        rst_n = 1'b0;
        bus.mmr_we = 1'b0; bus.mmr_location = 32'd0; bus.mmr_wdata = 32'd0;
        bus.noc_tx_ready = 1'b0;
        model_reset();
        #2;
        check("rst_valid", {31'd0, bus.noc_tx_valid}, 32'd0);
        check("rst_last",  {31'd0, bus.noc_tx_last},  32'd0);
        check("rst_done",  {31'd0, bus.noc_tx_done},  32'd0);
        check("rst_busy",  {31'd0, bus.busy},         32'd0);
        check("rst_stall", {31'd0, bus.mmr_stall},    32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic packet
        mmr_write(BASE + 32'h0, 32'h11, "basic_w0");
        mmr_write(BASE + 32'h4, 32'h22, "basic_w1");
        mmr_write(BASE + 32'h8, 32'h33, "basic_w2");
        mmr_write(BASE + 32'hC, 32'h44, "basic_w3");
        mmr_write(BASE + 32'h10, 32'h1, "basic_trig");
        run_packet(0, "basic", 0, 0, 32'd0);

        // Backpressure on flit 2
        mmr_write(BASE + 32'h10, 32'h1, "bp_trig");
        run_packet(2, "bp", 0, 0, 32'd0);

        // Write while busy is stalled, then retried in IDLE
        mmr_write(BASE + 32'h10, 32'h1, "busyw_trig");
        run_packet(0, "busyw", 1, 0, 32'd0);
        mmr_write(BASE + 32'h4, 32'h99, "busyw_retry");
        mmr_write(BASE + 32'h10, 32'h1, "busyw_trig2");
        run_packet(0, "busyw2", 0, 0, 32'd0);

        // Non-trigger command and missed writes
        mmr_write(BASE + 32'h10, 32'h0, "nontrig");
        for (int i = 0; i < 3; i++) begin
            #4;
            check("nontrig_valid", {31'd0, bus.noc_tx_valid}, 32'd0);
            check("nontrig_busy",  {31'd0, bus.busy},         32'd0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 5; i++) mmr_write(miss_addr[i], $urandom, "miss");
        mmr_write(BASE + 32'h10, 32'h3, "miss_trig");
        run_packet(0, "miss", 0, 0, 32'd0);

        // Back-to-back: trigger during DONE is stalled, taken in next IDLE cycle
        mmr_write(BASE + 32'h8, 32'hABCD_0001, "b2b_w2");
        mmr_write(BASE + 32'h10, 32'h5, "b2b_trig");
        run_packet(0, "b2b_a", 0, 1, 32'h0000_0107);
        run_packet(0, "b2b_b", 0, 0, 32'd0);

        // Randomized packets
        for (int p = 0; p < 15; p++) begin
            for (int k = 0; k < 5; k++) begin
                if ($urandom_range(0, 3) == 0)
                    mmr_write(miss_addr[$urandom_range(0, 4)], $urandom, "rnd_miss");
                else
                    mmr_write(BASE + 4 * $urandom_range(0, NW - 1), $urandom, "rnd_w");
            end
            cmdv = $urandom | 32'd1;
            mmr_write(BASE + 4 * NW, cmdv, "rnd_trig");
            run_packet(1, "rnd", 0, 0, 32'd0);
        end

        // Asynchronous reset in the middle of DATA
        mmr_write(BASE + 32'h0, 32'h5555_0000, "rstmid_w0");
        mmr_write(BASE + 32'h10, 32'h1, "rstmid_trig");
        bus.noc_tx_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1;
        check("rstmid_pre_valid", {31'd0, bus.noc_tx_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", {31'd0, bus.noc_tx_valid}, 32'd0);
        check("rstmid_last",  {31'd0, bus.noc_tx_last},  32'd0);
        check("rstmid_done",  {31'd0, bus.noc_tx_done},  32'd0);
        check("rstmid_busy",  {31'd0, bus.busy},         32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            #4;
            check("rstmid_after_valid", {31'd0, bus.noc_tx_valid}, 32'd0);
            @(posedge clk); #1;
        end
        mmr_write(BASE + 32'h10, 32'h1, "rstmid_retrig");
        run_packet(0, "rstmid_pkt", 0, 0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
